antirrebote_dual: RTL and testbench



---
 rtl/antirrebote_dual_pkg.sv | 16 +
 rtl/antirrebote_dual_if.sv | 28 ++
 rtl/antirrebote_dual_canal.sv | 105 ++++++++++
 rtl/antirrebote_dual.sv | 40 ++++
 tb/tb_antirrebote_dual.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/antirrebote_dual_pkg.sv
// Shared types for the dual-channel debouncer: per-channel FSM state encoding
// and the legal synchronizer-depth check.
package antirrebote_dual_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_RISE = 2'b01,
    ST_HIGH = 2'b11,
    ST_FALL = 2'b10
  } state_t;

  function automatic bit n_sync_legal(input int n);
    return (n >= 2) && (n <= 4);
  endfunction

endpackage

// File: rtl/antirrebote_dual_if.sv
// Raw button inputs and debounced level outputs for both channels.
// Rise-pulse signals exist only when ANTIRREBOTE_PULSE_EN is defined.
interface antirrebote_dual_if;
  logic i_btn_a;
  logic i_btn_b;
  logic o_a;
  logic o_b;
`ifdef ANTIRREBOTE_PULSE_EN
  logic o_a_rise;
  logic o_b_rise;
`endif

  modport master (
    output i_btn_a, i_btn_b,
    input  o_a, o_b
`ifdef ANTIRREBOTE_PULSE_EN
    , input o_a_rise, o_b_rise
`endif
  );

  modport slave (
    input  i_btn_a, i_btn_b,
    output o_a, o_b
`ifdef ANTIRREBOTE_PULSE_EN
    , output o_a_rise, o_b_rise
`endif
  );
endinterface

// File: rtl/antirrebote_dual_canal.sv
// One debounce channel: N_SYNC-deep synchronizer, 4-state FSM and stability counter.
// Optional registered rise pulse under ANTIRREBOTE_PULSE_EN.
module antirrebote_canal
  import antirrebote_dual_pkg::*;
#(
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic level
`ifdef ANTIRREBOTE_PULSE_EN
  , output logic rise
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (!n_sync_legal(N_SYNC)) begin : g_bad_n_sync
    $error("antirrebote_canal: N_SYNC must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("antirrebote_canal: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [N_SYNC-1:0] sync_p0;
  logic              s_x;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_p0 <= '0;
    else          sync_p0 <= {sync_p0[N_SYNC-2:0], btn};
  end

  assign s_x = sync_p0[N_SYNC-1];

  // --- FSM state register / next-state / output decode ---
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_LOW: if (s_x) begin
        state_nxt = ST_RISE;
        cnt_nxt   = CNT_W'(1);
      end
      ST_RISE: begin
        if (!s_x) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HIGH: if (!s_x) begin
        state_nxt = ST_FALL;
        cnt_nxt   = CNT_W'(1);
      end
      ST_FALL: begin
        if (s_x) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // HIGH and FALL share bit 1 of the encoding, so the level is a plain flop bit.
  always_comb begin
    level = (state == ST_HIGH) || (state == ST_FALL);
  end

`ifdef ANTIRREBOTE_PULSE_EN
  // Only the RISE->HIGH path qualifies; FALL->HIGH recoveries never pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rise <= 1'b0;
    else          rise <= (state == ST_RISE) && (state_nxt == ST_HIGH);
  end
`endif

endmodule

// File: rtl/antirrebote_dual.sv
// Two independent debounce channels feeding clean levels to the downstream logic.
// Rise pulses are built only when ANTIRREBOTE_PULSE_EN is defined.
module antirrebote_dual
  import antirrebote_dual_pkg::*;
#(
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic               clock,
  input logic               reset_n,
  antirrebote_dual_if.slave bus
);

  antirrebote_canal #(
    .N_SYNC          (N_SYNC),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_canal_a (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (bus.i_btn_a),
    .level   (bus.o_a)
`ifdef ANTIRREBOTE_PULSE_EN
    , .rise  (bus.o_a_rise)
`endif
  );

  antirrebote_canal #(
    .N_SYNC          (N_SYNC),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_canal_b (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (bus.i_btn_b),
    .level   (bus.o_b)
`ifdef ANTIRREBOTE_PULSE_EN
    , .rise  (bus.o_b_rise)
`endif
  );

endmodule

// File: tb/tb_antirrebote_dual.sv
// Bench for antirrebote_dual with N_SYNC=2, DEBOUNCE_CYCLES=4 (latency 5 cycles).
// Output level changes are matched against a queue of expected (channel, value, cycle) events.
module tb_antirrebote_dual;

  localparam int L = 5;

  typedef struct {
    int   ch;
    logic val;
    int   at;
  } ev_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  logic pa      = 1'b0;
  logic pb      = 1'b0;
  ev_t  q[$];

  antirrebote_dual_if bus ();

  antirrebote_dual #(
    .N_SYNC          (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Input driven now is first sampled at the next edge; output follows L edges later.
  task automatic expect_ev(input int ch, input logic v);
    ev_t e;
    e.ch  = ch;
    e.val = v;
    e.at  = cyc + 1 + L;
    q.push_back(e);
  endtask

  task automatic check_lvl(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic seen(input int ch, input logic v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_change: ch%0d went to %b at cycle %0d, expected no change", ch, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.ch != ch || e.val !== v || e.at != cyc) begin
        errors++;
        $display("FAIL level_edge: got ch%0d=%b at cycle %0d, expected ch%0d=%b at cycle %0d",
                 ch, v, cyc, e.ch, e.val, e.at);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench still running at %0t, expected to finish before 20000", $time);
    $fatal(1);
  end

  initial begin
    bus.i_btn_a = 1'b1;
    bus.i_btn_b = 1'b1;

    fork
      forever begin
        @(negedge clock);
        if (!reset_n) begin
          pa = 1'b0;
          pb = 1'b0;
        end else begin
`ifdef ANTIRREBOTE_PULSE_EN
          check_lvl("rise_a", bus.o_a_rise, bus.o_a && !pa);
          check_lvl("rise_b", bus.o_b_rise, bus.o_b && !pb);
`endif
          if (bus.o_a !== pa) begin
            seen(0, bus.o_a);
            pa = bus.o_a;
          end
          if (bus.o_b !== pb) begin
            seen(1, bus.o_b);
            pb = bus.o_b;
          end
        end
      end
    join_none

    // Reset held with both buttons pressed, then released
    tick(3);
    check_lvl("reset_o_a", bus.o_a, 1'b0);
    check_lvl("reset_o_b", bus.o_b, 1'b0);
    reset_n = 1'b1;
    expect_ev(0, 1'b1);
    expect_ev(1, 1'b1);
    tick(10);

    // Clean release on each channel
    bus.i_btn_a = 1'b0; expect_ev(0, 1'b0);
    tick(10);
    bus.i_btn_b = 1'b0; expect_ev(1, 1'b0);
    tick(10);

    // Three-cycle glitch is rejected
    bus.i_btn_a = 1'b1; tick(3);
    bus.i_btn_a = 1'b0; tick(12);
    check_lvl("glitch_o_a", bus.o_a, 1'b0);

    // Bounce 1,0,1,0,1 then hold
    bus.i_btn_a = 1'b1; tick(1);
    bus.i_btn_a = 1'b0; tick(1);
    bus.i_btn_a = 1'b1; tick(1);
    bus.i_btn_a = 1'b0; tick(1);
    bus.i_btn_a = 1'b1; expect_ev(0, 1'b1);
    tick(12);

    // Two-cycle dip while high is absorbed
    bus.i_btn_a = 1'b0; tick(2);
    bus.i_btn_a = 1'b1; tick(12);
    check_lvl("dip_o_a", bus.o_a, 1'b1);
    bus.i_btn_a = 1'b0; expect_ev(0, 1'b0);
    tick(10);

    // Simultaneous steps, then B alone
    bus.i_btn_a = 1'b1; bus.i_btn_b = 1'b1;
    expect_ev(0, 1'b1); expect_ev(1, 1'b1);
    tick(10);
    bus.i_btn_b = 1'b0; expect_ev(1, 1'b0);
    tick(10);
    bus.i_btn_b = 1'b1; expect_ev(1, 1'b1);
    tick(10);
    bus.i_btn_a = 1'b0; bus.i_btn_b = 1'b0;
    expect_ev(0, 1'b0); expect_ev(1, 1'b0);
    tick(10);

    // B high, A mid-count (RISE, cnt=2) when reset hits between edges
    bus.i_btn_b = 1'b1; expect_ev(1, 1'b1);
    tick(10);
    bus.i_btn_a = 1'b1; expect_ev(0, 1'b1);
    tick(4);
    #1;
    reset_n = 1'b0;
    #1;
    check_lvl("midreset_o_a", bus.o_a, 1'b0);
    check_lvl("midreset_o_b", bus.o_b, 1'b0);
    q.delete();
    bus.i_btn_a = 1'b0;
    bus.i_btn_b = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(12);
    check_lvl("post_reset_o_a", bus.o_a, 1'b0);
    check_lvl("post_reset_o_b", bus.o_b, 1'b0);
    check_lvl("queue_drained", q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
